// File: rtl/freq_set_ctrl.sv
// Frequency-setting controller: BCD setpoint with clamped fine/coarse keys,
// sequential BCD->binary conversion and serial division into a half-period load.
module freq_set_ctrl #(
    parameter int          CLK_HZ      = 50_000_000,
    parameter logic [23:0] DEFAULT_BCD = 24'h001000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_fine,
    input  logic        dec_fine,
    input  logic        inc_coarse,
    input  logic        dec_coarse,
    output logic [23:0] bcd,
    output logic [19:0] freq_bin,
    output logic [31:0] half_period,
    output logic        load,
    output logic        busy
);
    typedef enum logic [2:0] {
        ST_START,
        ST_IDLE,
        ST_CONVERT,
        ST_DIVIDE,
        ST_LOAD
    } state_t;

    localparam logic [31:0] DIVIDEND = 32'(CLK_HZ / 2);

    state_t      state_q, state_d;
    logic [23:0] bcd_q, bcd_d;
    logic [19:0] freq_q, freq_d;
    logic [31:0] half_q, half_d;
    logic        load_q, load_d;
    logic        busy_q, busy_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [19:0] acc_q, acc_d;
    logic [19:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;

    logic [3:0]  digit;
    logic [19:0] acc_next;
    logic [20:0] rem_sh;
    logic [20:0] rem_sub;
    logic        rem_ge;
    logic        key_go;

    // Adds or subtracts one at digit k, rippling carry/borrow upward.
    // Callers clamp beforehand, so the top digit never wraps.
    function automatic logic [23:0] bcd_step(input logic [23:0] v, input int k, input logic up);
        logic [23:0] r;
        logic        c;
        logic [3:0]  d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = r[i*4 +: 4];
            if (c && (i >= k)) begin
                if (up) begin
                    if (d == 4'd9) r[i*4 +: 4] = 4'd0;
                    else begin
                        r[i*4 +: 4] = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) r[i*4 +: 4] = 4'd9;
                    else begin
                        r[i*4 +: 4] = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] get_digit(input logic [23:0] v, input logic [2:0] idx);
        return v[{idx, 2'b00} +: 4];
    endfunction

    always_comb begin
        state_d  = state_q;
        bcd_d    = bcd_q;
        freq_d   = freq_q;
        half_d   = half_q;
        load_d   = 1'b0;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        key_go   = 1'b0;

        digit    = get_digit(bcd_q, 3'd5 - cnt_q[2:0]);
        acc_next = acc_q * 20'd10 + {16'd0, digit};
        rem_sh   = {rem_q, DIVIDEND[5'd31 - cnt_q]};
        rem_ge   = (rem_sh >= {1'b0, freq_q});
        rem_sub  = rem_sh - {1'b0, freq_q};

        case (state_q)
            ST_START: begin
                key_go = 1'b1;
            end
            ST_IDLE: begin
                case ({inc_fine, dec_fine, inc_coarse, dec_coarse})
                    4'b1000: begin
                        bcd_d  = (bcd_q == 24'h999999) ? bcd_q : bcd_step(bcd_q, 0, 1'b1);
                        key_go = 1'b1;
                    end
                    4'b0100: begin
                        bcd_d  = (bcd_q == 24'h000001) ? bcd_q : bcd_step(bcd_q, 0, 1'b0);
                        key_go = 1'b1;
                    end
                    4'b0010: begin
                        bcd_d  = (bcd_q > 24'h989999) ? 24'h999999 : bcd_step(bcd_q, 4, 1'b1);
                        key_go = 1'b1;
                    end
                    4'b0001: begin
                        bcd_d  = (bcd_q < 24'h010001) ? 24'h000001 : bcd_step(bcd_q, 4, 1'b0);
                        key_go = 1'b1;
                    end
                    default: key_go = 1'b0;
                endcase
            end
            ST_CONVERT: begin
                acc_d = acc_next;
                if (cnt_q == 5'd5) begin
                    freq_d  = acc_next;
                    state_d = ST_DIVIDE;
                    cnt_d   = 5'd0;
                    rem_d   = 20'd0;
                    quo_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_DIVIDE: begin
                rem_d = rem_ge ? rem_sub[19:0] : rem_sh[19:0];
                quo_d = {quo_q[30:0], rem_ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // First LOAD edge publishes the quotient, the second releases busy.
                if (!load_q) begin
                    half_d = quo_q;
                    load_d = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_START;
        endcase

        if (key_go) begin
            state_d = ST_CONVERT;
            busy_d  = 1'b1;
            cnt_d   = 5'd0;
            acc_d   = 20'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_START;
            bcd_q   <= DEFAULT_BCD;
            freq_q  <= 20'd0;
            half_q  <= 32'd0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= 5'd0;
            acc_q   <= 20'd0;
            rem_q   <= 20'd0;
            quo_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            freq_q  <= freq_d;
            half_q  <= half_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
        end
    end

    assign bcd         = bcd_q;
    assign freq_bin    = freq_q;
    assign half_period = half_q;
    assign load        = load_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_freq_set_ctrl.sv
// Bench for freq_set_ctrl: key table plus hand sequences; load pulses are
// checked against a queue of expected half-period values and load edges.
module tb_freq_set_ctrl;
    logic        clk;
    logic        rst_n;
    logic        inc_fine, dec_fine, inc_coarse, dec_coarse;
    logic [23:0] bcd;
    logic [19:0] freq_bin;
    logic [31:0] half_period;
    logic        load;
    logic        busy;

    freq_set_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_fine   (inc_fine),
        .dec_fine   (dec_fine),
        .inc_coarse (inc_coarse),
        .dec_coarse (dec_coarse),
        .bcd        (bcd),
        .freq_bin   (freq_bin),
        .half_period(half_period),
        .load       (load),
        .busy       (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_total = 0;
    int n_bad   = 0;
    int n_loads = 0;

    logic [31:0] exp_q[$];
    int          edge_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=0x%0h (%0d) required=0x%0h (%0d) t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int bcd2int(input logic [23:0] v);
        int r;
        r = 0;
        for (int i = 5; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [23:0] int2bcd(input int v);
        logic [23:0] r;
        int          t;
        t = v;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_half(input logic [23:0] v);
        return 32'(25_000_000 / bcd2int(v));
    endfunction

    // scoreboard: every load pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n && load) begin
            n_loads++;
            if (exp_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL unexpected_load actual=1 required=0 t=%0t", $time);
            end else begin
                chk("half_period", half_period, exp_q.pop_front());
                chk("load_edge", 32'(edge_n), 32'(edge_q.pop_front()));
            end
        end
    end

    // driver: one key press, then follow the whole busy window
    task automatic press(input logic [3:0] keys, input logic [23:0] exp_bcd,
                         input logic exp_ld, input logic poke);
        int          busy_n;
        int          loads0;
        logic [23:0] old;
        old    = bcd;
        loads0 = n_loads;
        @(posedge clk); #1;
        {inc_fine, dec_fine, inc_coarse, dec_coarse} = keys;
        if (exp_ld) begin
            exp_q.push_back(exp_half(exp_bcd));
            edge_q.push_back(edge_n + 1 + 39);
        end
        @(posedge clk); #1;
        {inc_fine, dec_fine, inc_coarse, dec_coarse} = 4'b0000;
        chk("bcd_after_key", 32'(bcd), 32'(exp_bcd));
        if (exp_ld) begin
            busy_n = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (!busy) break;
                busy_n++;
                inc_fine = (poke && busy_n == 10);
            end
            inc_fine = 1'b0;
            chk("busy_cycles", 32'(busy_n), 32'd40);
            chk("freq_bin", 32'(freq_bin), 32'(bcd2int(exp_bcd)));
            chk("bcd_stable", 32'(bcd), 32'(exp_bcd));
            chk("load_count", 32'(n_loads - loads0), 32'd1);
        end else begin
            @(negedge clk);
            chk("busy_ignored", 32'(busy), 32'd0);
            repeat (45) @(negedge clk);
            chk("no_load", 32'(n_loads - loads0), 32'd0);
            chk("bcd_unchanged", 32'(bcd), 32'(old));
        end
    endtask

    // waits for a start-up sequence to finish, bounded
    task automatic settle();
        int n;
        n = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        chk("startup_busy_cycles", 32'(n), 32'd40);
    endtask

    typedef struct {
        logic [3:0]  keys;   // {inc_fine, dec_fine, inc_coarse, dec_coarse}
        logic [23:0] bcd;
        logic        ld;
        logic        poke;
    } vec_t;

    vec_t tbl[17];
    int   mv;

    initial begin
        tbl[0]  = '{4'b1000, 24'h001001, 1'b1, 1'b1};
        tbl[1]  = '{4'b0100, 24'h001000, 1'b1, 1'b0};
        tbl[2]  = '{4'b0010, 24'h011000, 1'b1, 1'b0};
        tbl[3]  = '{4'b0001, 24'h001000, 1'b1, 1'b0};
        tbl[4]  = '{4'b0001, 24'h000001, 1'b1, 1'b0};
        tbl[5]  = '{4'b0100, 24'h000001, 1'b1, 1'b0};
        tbl[6]  = '{4'b0010, 24'h010001, 1'b1, 1'b0};
        tbl[7]  = '{4'b1100, 24'h010001, 1'b0, 1'b0};
        tbl[8]  = '{4'b0011, 24'h010001, 1'b0, 1'b0};
        tbl[9]  = '{4'b0100, 24'h010000, 1'b1, 1'b0};
        tbl[10] = '{4'b0100, 24'h009999, 1'b1, 1'b0};
        tbl[11] = '{4'b1000, 24'h010000, 1'b1, 1'b0};
        tbl[12] = '{4'b1000, 24'h010001, 1'b1, 1'b0};
        tbl[13] = '{4'b0001, 24'h000001, 1'b1, 1'b0};
        tbl[14] = '{4'b0010, 24'h010001, 1'b1, 1'b0};
        tbl[15] = '{4'b0100, 24'h010000, 1'b1, 1'b0};
        tbl[16] = '{4'b0001, 24'h000001, 1'b1, 1'b0};

        rst_n = 1'b0;
        {inc_fine, dec_fine, inc_coarse, dec_coarse} = 4'b0000;
        repeat (3) @(negedge clk);
        chk("rst_bcd", 32'(bcd), 32'h001000);
        chk("rst_freq_bin", 32'(freq_bin), 32'd0);
        chk("rst_half_period", half_period, 32'd0);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // start-up load for the default setpoint
        exp_q.push_back(32'd25000);
        edge_q.push_back(edge_n + 1 + 39);
        rst_n = 1'b1;
        settle();
        chk("startup_freq_bin", 32'(freq_bin), 32'd1000);
        chk("startup_bcd", 32'(bcd), 32'h001000);
        chk("startup_half", half_period, 32'd25000);

        for (int i = 0; i < 17; i++) press(tbl[i].keys, tbl[i].bcd, tbl[i].ld, tbl[i].poke);

        // climb to the top with coarse presses, then hit the upper clamps
        mv = 1;
        for (int i = 0; i < 120; i++) begin
            if (mv == 999999) break;
            mv = (mv > 989999) ? 999999 : mv + 10000;
            press(4'b0010, int2bcd(mv), 1'b1, 1'b0);
        end
        chk("reached_top", 32'(bcd), 32'h999999);
        press(4'b1000, 24'h999999, 1'b1, 1'b0);
        press(4'b0010, 24'h999999, 1'b1, 1'b0);
        press(4'b0001, 24'h989999, 1'b1, 1'b0);
        press(4'b0010, 24'h999999, 1'b1, 1'b0);
        press(4'b0100, 24'h999998, 1'b1, 1'b0);

        // reset in the middle of a division
        @(posedge clk); #1;
        inc_fine = 1'b1;
        @(posedge clk); #1;
        inc_fine = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_load", 32'(load), 32'd0);
        chk("mid_rst_half", half_period, 32'd0);
        chk("mid_rst_bcd", 32'(bcd), 32'h001000);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_freq", 32'(freq_bin), 32'd0);
        @(negedge clk);
        exp_q.push_back(32'd25000);
        edge_q.push_back(edge_n + 1 + 39);
        rst_n = 1'b1;
        settle();
        chk("restart_half", half_period, 32'd25000);
        chk("restart_freq", 32'(freq_bin), 32'd1000);

        repeat (5) @(negedge clk);
        chk("pending_loads", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
